// File: rtl/apb_demux_pkg.sv
// Shared AMBA widths, demux state encodings and helpers for the APB address demux.
`ifndef AMBA_DEFINE_V
`define AMBA_DEFINE_V
`define P_ADDR_W 32
`define P_DATA_W 32
`define P_STRB_W 4
`define APB_DMX_IDLE   1'b0
`define APB_DMX_ACCESS 1'b1
`endif

package apb_demux_pkg;

  localparam int unsigned ADDR_W = `P_ADDR_W;
  localparam int unsigned DATA_W = `P_DATA_W;
  localparam int unsigned STRB_W = `P_STRB_W;

  typedef enum logic {
    ST_IDLE   = `APB_DMX_IDLE,
    ST_ACCESS = `APB_DMX_ACCESS
  } dmx_state_e;

  // Counter width able to hold max_val; never below one bit so a disabled timeout still elaborates.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val == 0) ? 1 : int'($clog2(max_val + 1));
  endfunction

endpackage

// File: rtl/apb_addr_dec.sv
// Combinational base/mask address decoder with lowest-index priority on overlapping windows.
module apb_addr_dec
  import apb_demux_pkg::*;
#(
  parameter int unsigned                  NUM_SLV  = 4,
  parameter int unsigned                  AW       = ADDR_W,
  parameter logic [NUM_SLV*AW-1:0]        SLV_BASE = '0,
  parameter logic [NUM_SLV*AW-1:0]        SLV_MASK = '0
) (
  input  logic [AW-1:0]      paddr,
  input  logic               psel,
  output logic [NUM_SLV-1:0] pri_hit,
  output logic               miss
);

  logic [NUM_SLV-1:0] hit;
  logic               found;

  always_comb begin
    hit     = '0;
    pri_hit = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      hit[i] = ((paddr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]);
    end
    for (int i = 0; i < NUM_SLV; i++) begin
      if (hit[i] && !found) begin
        pri_hit[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign miss = psel && !(|hit);

endmodule

// File: rtl/apb_demux.sv
// APB 1:N address demux: decodes in SETUP, holds the selection through ACCESS,
// and answers unmapped or stalled transfers itself with PSLVERR.
module apb_demux
  import apb_demux_pkg::*;
#(
  parameter int unsigned                 NUM_SLV     = 4,
  parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_BASE    = {32'h0000_3000, 32'h0000_2000,
                                                        32'h0000_1000, 32'h0000_0000},
  parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_MASK    = {4{32'h0000_F000}},
  parameter int unsigned                 TIMEOUT_CYC = 255
) (
  input  logic                        pclk,
  input  logic                        presetn,
  input  logic [ADDR_W-1:0]           s_paddr,
  input  logic                        s_psel,
  input  logic                        s_penable,
  input  logic                        s_pwrite,
  input  logic [DATA_W-1:0]           s_pwdata,
  input  logic [STRB_W-1:0]           s_pwstrb,
  output logic                        s_pready,
  output logic [DATA_W-1:0]           s_prdata,
  output logic                        s_pslverr,
  output logic [ADDR_W-1:0]           m_paddr,
  output logic [NUM_SLV-1:0]          m_psel,
  output logic                        m_penable,
  output logic                        m_pwrite,
  output logic [DATA_W-1:0]           m_pwdata,
  output logic [STRB_W-1:0]           m_pwstrb,
  input  logic [NUM_SLV-1:0]          m_pready,
  input  logic [NUM_SLV*DATA_W-1:0]   m_prdata,
  input  logic [NUM_SLV-1:0]          m_pslverr
);

  localparam int unsigned TW = cnt_w(TIMEOUT_CYC);

  dmx_state_e         state;
  logic [NUM_SLV-1:0] pri_hit;
  logic [NUM_SLV-1:0] sel_q;
  logic               miss;
  logic               miss_q;
  logic [TW-1:0]      tcnt;
  logic               in_access;
  logic               setup_req;
  logic               timeout;
  logic               hit_ready;
  logic               hit_err;
  logic [DATA_W-1:0]  hit_rdata;

  apb_addr_dec #(
    .NUM_SLV  (NUM_SLV),
    .AW       (ADDR_W),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_dec (
    .paddr   (s_paddr),
    .psel    (s_psel),
    .pri_hit (pri_hit),
    .miss    (miss)
  );

  assign in_access = (state == ST_ACCESS);
  assign setup_req = s_psel && !s_penable;
  assign timeout   = (TIMEOUT_CYC != 0) && in_access && !miss_q && (tcnt == TW'(TIMEOUT_CYC));

  // A stray SETUP during ACCESS is a protocol error and is ignored; the transfer keeps going.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state  <= ST_IDLE;
      sel_q  <= '0;
      miss_q <= 1'b0;
      tcnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (setup_req) begin
            state  <= ST_ACCESS;
            sel_q  <= pri_hit;
            miss_q <= miss;
            tcnt   <= '0;
          end
        end
        ST_ACCESS: begin
          if (!s_psel || (s_penable && s_pready)) begin
            state  <= ST_IDLE;
            sel_q  <= '0;
            miss_q <= 1'b0;
            tcnt   <= '0;
          end else if (s_penable && (tcnt != TW'(TIMEOUT_CYC))) begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // AND-OR response mux over the one-hot held selection.
  always_comb begin
    hit_ready = 1'b0;
    hit_err   = 1'b0;
    hit_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      hit_ready = hit_ready | (m_pready[i]  & sel_q[i]);
      hit_err   = hit_err   | (m_pslverr[i] & sel_q[i]);
      hit_rdata = hit_rdata | (m_prdata[i*DATA_W +: DATA_W] & {DATA_W{sel_q[i]}});
    end
  end

  always_comb begin
    s_pready  = 1'b0;
    s_pslverr = 1'b0;
    s_prdata  = '0;
    if (in_access) begin
      if (miss_q || timeout) begin
        s_pready  = 1'b1;
        s_pslverr = 1'b1;
      end else begin
        s_pready  = hit_ready;
        s_pslverr = hit_err;
        s_prdata  = hit_rdata;
      end
    end
  end

  // SETUP reaches the completer in the same cycle; a timed-out completer loses PSEL.
  always_comb begin
    m_psel = '0;
    if (presetn) begin
      if (in_access) begin
        m_psel = timeout ? '0 : (sel_q & {NUM_SLV{s_psel}});
      end else begin
        m_psel = pri_hit & {NUM_SLV{s_psel}};
      end
    end
  end

  // Broadcast request fields read zero while reset is asserted.
  assign m_paddr   = presetn ? s_paddr   : '0;
  assign m_penable = presetn && s_penable;
  assign m_pwrite  = presetn && s_pwrite;
  assign m_pwdata  = presetn ? s_pwdata  : '0;
  assign m_pwstrb  = presetn ? s_pwstrb  : '0;

endmodule

// File: tb/tb_apb_demux.sv
// Self-checking bench for apb_demux: vector table driven through an APB requester task,
// expected completions queued at SETUP and compared when the demux answers.
module tb_apb_demux;
  import apb_demux_pkg::*;

  localparam int unsigned NS     = 4;
  localparam int unsigned TO     = 8;
  localparam int          BUDGET = 20;
  // Slot 0 and slot 2 both claim 0x2000; slot 2 also covers 0x3xxx.
  localparam logic [NS*ADDR_W-1:0] BASE = {32'h0000_4000, 32'h0000_2000, 32'h0000_1000, 32'h0000_2000};
  localparam logic [NS*ADDR_W-1:0] MASK = {32'h0000_F000, 32'h0000_E000, 32'h0000_F000, 32'h0000_F000};

  logic                   clk = 1'b0;
  logic                   presetn;
  logic [ADDR_W-1:0]      s_paddr;
  logic                   s_psel;
  logic                   s_penable;
  logic                   s_pwrite;
  logic [DATA_W-1:0]      s_pwdata;
  logic [STRB_W-1:0]      s_pwstrb;
  logic                   s_pready;
  logic [DATA_W-1:0]      s_prdata;
  logic                   s_pslverr;
  logic [ADDR_W-1:0]      m_paddr;
  logic [NS-1:0]          m_psel;
  logic                   m_penable;
  logic                   m_pwrite;
  logic [DATA_W-1:0]      m_pwdata;
  logic [STRB_W-1:0]      m_pwstrb;
  logic [NS-1:0]          m_pready;
  logic [NS*DATA_W-1:0]   m_prdata;
  logic [NS-1:0]          m_pslverr;

  int n_tests = 0;
  int n_fail  = 0;
  int wcnt [NS];

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] rdata;
    logic        err;
    int          cycles;
    logic        to;
    int          gap;
  } vec_t;

  vec_t vecs [9];
  vec_t sbq [$];

  always #5 clk = ~clk;

  apb_demux #(
    .NUM_SLV     (NS),
    .SLV_BASE    (BASE),
    .SLV_MASK    (MASK),
    .TIMEOUT_CYC (TO)
  ) dut (
    .pclk      (clk),
    .presetn   (presetn),
    .s_paddr   (s_paddr),
    .s_psel    (s_psel),
    .s_penable (s_penable),
    .s_pwrite  (s_pwrite),
    .s_pwdata  (s_pwdata),
    .s_pwstrb  (s_pwstrb),
    .s_pready  (s_pready),
    .s_prdata  (s_prdata),
    .s_pslverr (s_pslverr),
    .m_paddr   (m_paddr),
    .m_psel    (m_psel),
    .m_penable (m_penable),
    .m_pwrite  (m_pwrite),
    .m_pwdata  (m_pwdata),
    .m_pwstrb  (m_pwstrb),
    .m_pready  (m_pready),
    .m_prdata  (m_prdata),
    .m_pslverr (m_pslverr)
  );

  function automatic int slv_wait(input int i);
    case (i)
      0: return 0;
      1: return 2;
      2: return 1000;
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] slv_rdata(input int i);
    case (i)
      0: return 32'h1111_0000;
      1: return 32'hA5A5_A5A5;
      2: return 32'h2222_2222;
      default: return 32'h3333_3333;
    endcase
  endfunction

  // Completer models: fixed wait states, constant read data and error flag per slot.
  always_comb begin
    for (int i = 0; i < NS; i++) begin
      m_pready[i]                   = m_psel[i] && m_penable && (wcnt[i] == slv_wait(i));
      m_prdata[i*DATA_W +: DATA_W]  = slv_rdata(i);
      m_pslverr[i]                  = (i == 3);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (m_psel[i] && m_penable && !m_pready[i]) wcnt[i] <= wcnt[i] + 1;
      else                                         wcnt[i] <= 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input logic write, input logic [31:0] wdata,
                              input logic [3:0] sel, input logic [31:0] rdata, input logic err,
                              input int cycles, input logic to, input int gap);
    vec_t v;
    v.addr = addr; v.write = write; v.wdata = wdata; v.sel = sel; v.rdata = rdata;
    v.err = err; v.cycles = cycles; v.to = to; v.gap = gap;
    return v;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      s_psel = 1'b0; s_penable = 1'b0;
    end
  endtask

  // One APB transfer: SETUP then ACCESS until s_pready, bounded by BUDGET cycles.
  task automatic run_xfer(input vec_t v);
    vec_t e;
    int   n;
    bit   done;
    @(posedge clk); #1;
    s_psel = 1'b1; s_penable = 1'b0; s_paddr = v.addr;
    s_pwrite = v.write; s_pwdata = v.wdata; s_pwstrb = 4'hF;
    sbq.push_back(v);
    @(negedge clk);
    check("setup_psel",  32'(m_psel), 32'(v.sel));
    check("setup_ready", 32'(s_pready), 32'd0);
    check("fwd_addr",    m_paddr, v.addr);
    check("fwd_write",   32'(m_pwrite), 32'(v.write));
    check("fwd_wdata",   m_pwdata, v.wdata);
    @(posedge clk); #1;
    s_penable = 1'b1;
    n = 0;
    done = 1'b0;
    while (!done && n < BUDGET) begin
      @(negedge clk);
      n++;
      check("access_psel", 32'(m_psel), (v.to && n == v.cycles) ? 32'd0 : 32'(v.sel));
      if (s_pready) begin
        done = 1'b1;
        e = sbq.pop_front();
        check("cycles", 32'(n), 32'(e.cycles));
        check("rdata",  s_prdata, e.rdata);
        check("pslverr", 32'(s_pslverr), 32'(e.err));
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout_wait: no s_pready for addr %h within %0d cycles", v.addr, BUDGET);
      void'(sbq.pop_front());
      s_psel = 1'b0; s_penable = 1'b0;
    end
    idle(v.gap);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(32'h1004, 1'b0, 32'h0,         4'b0010, 32'hA5A5_A5A5, 1'b0, 3, 1'b0, 1);
    vecs[1] = mk(32'h9000, 1'b1, 32'hDEAD_BEEF, 4'b0000, 32'h0,         1'b1, 1, 1'b0, 1);
    vecs[2] = mk(32'h3004, 1'b0, 32'h0,         4'b0100, 32'h0,         1'b1, TO + 1, 1'b1, 0);
    vecs[3] = mk(32'h1008, 1'b0, 32'h0,         4'b0010, 32'hA5A5_A5A5, 1'b0, 3, 1'b0, 0);
    vecs[4] = mk(32'h2010, 1'b1, 32'h1234_5678, 4'b0001, 32'h1111_0000, 1'b0, 1, 1'b0, 0);
    vecs[5] = mk(32'h4000, 1'b0, 32'h0,         4'b1000, 32'h3333_3333, 1'b1, 2, 1'b0, 0);
    vecs[6] = mk(32'h2000, 1'b0, 32'h0,         4'b0001, 32'h1111_0000, 1'b0, 1, 1'b0, 1);
    vecs[7] = mk(32'hF000, 1'b0, 32'h0,         4'b0000, 32'h0,         1'b1, 1, 1'b0, 0);
    vecs[8] = mk(32'h1000, 1'b0, 32'h0,         4'b0010, 32'hA5A5_A5A5, 1'b0, 3, 1'b0, 1);

    presetn = 1'b0;
    s_psel = 1'b1; s_penable = 1'b1; s_pwrite = 1'b1;
    s_paddr = 32'h1004; s_pwdata = 32'hFFFF_FFFF; s_pwstrb = 4'hF;
    repeat (2) @(negedge clk);
    check("rst_pready",  32'(s_pready), 32'd0);
    check("rst_prdata",  s_prdata, 32'd0);
    check("rst_pslverr", 32'(s_pslverr), 32'd0);
    check("rst_psel",    32'(m_psel), 32'd0);
    check("rst_paddr",   m_paddr, 32'd0);
    check("rst_penable", 32'(m_penable), 32'd0);
    check("rst_pwdata",  m_pwdata, 32'd0);
    @(posedge clk); #1;
    presetn = 1'b1; s_psel = 1'b0; s_penable = 1'b0; s_pwrite = 1'b0;
    idle(2);

    for (int k = 0; k < 9; k++) run_xfer(vecs[k]);

    // Upstream abort: PSEL dropped after one ACCESS cycle, next SETUP must decode from IDLE.
    @(posedge clk); #1;
    s_psel = 1'b1; s_penable = 1'b0; s_paddr = 32'h1004; s_pwrite = 1'b0;
    @(posedge clk); #1;
    s_penable = 1'b1;
    @(negedge clk);
    check("abort_psel_acc", 32'(m_psel), 32'b0010);
    check("abort_ready",    32'(s_pready), 32'd0);
    @(posedge clk); #1;
    s_psel = 1'b0; s_penable = 1'b0;
    @(negedge clk);
    check("abort_psel_drop", 32'(m_psel), 32'd0);
    run_xfer(vecs[5]);

    // Asynchronous reset while slave1 is inserting wait states.
    @(posedge clk); #1;
    s_psel = 1'b1; s_penable = 1'b0; s_paddr = 32'h1004; s_pwrite = 1'b0;
    @(posedge clk); #1;
    s_penable = 1'b1;
    @(negedge clk);
    check("mid_psel",  32'(m_psel), 32'b0010);
    check("mid_ready", 32'(s_pready), 32'd0);
    #2 presetn = 1'b0;
    #1;
    check("arst_psel",    32'(m_psel), 32'd0);
    check("arst_pready",  32'(s_pready), 32'd0);
    check("arst_penable", 32'(m_penable), 32'd0);
    check("arst_paddr",   m_paddr, 32'd0);
    @(posedge clk); #1;
    s_psel = 1'b0; s_penable = 1'b0;
    @(posedge clk); #1;
    presetn = 1'b1;
    idle(1);
    run_xfer(vecs[0]);

    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
